// File: rtl/mcc_pkg.sv
// Constants and enums shared by the MCC crossbar read/write side controllers.
package mcc_pkg;

    localparam int XBAR_SIZE     = 32;
    localparam int XBAR_SIZE_BIN = 5;
    localparam int DATA_WIDTH    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SELECT  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DRAIN   = 2'd3
    } coll_state_t;

    typedef enum logic [1:0] {
        ACC_OP_ADD       = 2'd0,
        ACC_OP_OVERWRITE = 2'd1,
        ACC_OP_CLEAR     = 2'd2
    } acc_op_t;

endpackage

// File: rtl/mcc_acc_bank.sv
// Per-column partial-sum register file: one add/overwrite/clear write port, one async read port.
// MCC_ACC_SAT_EN selects saturating accumulation; otherwise sums wrap.
module mcc_acc_bank
    import mcc_pkg::*;
#(
    parameter int ACC_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_wr_en,
    input  acc_op_t                  i_wr_op,
    input  logic [XBAR_SIZE_BIN-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_wr_data,
    input  logic [XBAR_SIZE_BIN-1:0] i_rd_addr,
    output logic [ACC_WIDTH-1:0]     o_rd_data
);

    localparam int SUM_WIDTH = ACC_WIDTH + 1;

    logic [ACC_WIDTH-1:0] r_acc [XBAR_SIZE];
    logic [SUM_WIDTH-1:0] w_sum;
    logic [ACC_WIDTH-1:0] w_add;
    logic [ACC_WIDTH-1:0] w_wr_val;

    // One extra bit catches the carry so saturation can see the overflow.
    assign w_sum = {1'b0, r_acc[i_wr_addr]} + SUM_WIDTH'(i_wr_data);

`ifdef MCC_ACC_SAT_EN
    assign w_add = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_add = w_sum[ACC_WIDTH-1:0];
`endif

    always_comb begin
        w_wr_val = '0;
        case (i_wr_op)
            ACC_OP_ADD:       w_wr_val = w_add;
            ACC_OP_OVERWRITE: w_wr_val = ACC_WIDTH'(i_wr_data);
            default:          w_wr_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < XBAR_SIZE; i++) begin
                r_acc[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_acc[i_wr_addr] <= w_wr_val;
        end
    end

    assign o_rd_data = r_acc[i_rd_addr];

endmodule

// File: rtl/mcc_adc_collector.sv
// Sequences the shared ADC over the crossbar columns, accumulates samples, and drains the y vector.
// Build with MCC_ACC_SAT_EN for saturating accumulation (see mcc_acc_bank).
module mcc_adc_collector
    import mcc_pkg::*;
#(
    parameter int ACC_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_start,
    input  logic                     i_accum,
    input  logic                     i_flush,
    output logic [XBAR_SIZE_BIN-1:0] o_mux_sel,
    output logic                     o_adc_req,
    input  logic [DATA_WIDTH-1:0]    i_adc_data,
    input  logic                     i_adc_valid,
    output logic [ACC_WIDTH-1:0]     o_y_value,
    output logic [XBAR_SIZE_BIN-1:0] o_y_index,
    output logic                     o_y_valid,
    input  logic                     i_y_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output coll_state_t              o_dbg_state
);

    // Handshakes: a y beat transfers on a cycle with o_y_valid && i_y_ready; o_y_valid stays up and
    // y_value/y_index stay stable until then. o_adc_req stays up until the cycle i_adc_valid is seen.

    localparam logic [3:0]               SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [XBAR_SIZE_BIN-1:0] COL_LAST    = XBAR_SIZE_BIN'(XBAR_SIZE - 1);

    coll_state_t              r_state, w_state_nxt;
    logic [XBAR_SIZE_BIN-1:0] r_col, w_col_nxt;
    logic [3:0]               r_settle, w_settle_nxt;
    logic                     r_accum_mode, w_accum_nxt;
    logic [XBAR_SIZE_BIN-1:0] r_mux_sel, w_mux_nxt;
    logic                     r_adc_req;
    logic                     r_y_valid;
    logic [XBAR_SIZE_BIN-1:0] r_y_index, w_y_index_nxt;
    logic                     r_done, w_done_nxt;

    logic                     w_wr_en;
    acc_op_t                  w_wr_op;
    logic [XBAR_SIZE_BIN-1:0] w_wr_addr;
    logic [ACC_WIDTH-1:0]     w_rd_data;

    always_comb begin
        w_state_nxt   = r_state;
        w_col_nxt     = r_col;
        w_settle_nxt  = r_settle;
        w_accum_nxt   = r_accum_mode;
        w_y_index_nxt = r_y_index;
        w_done_nxt    = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_op       = ACC_OP_OVERWRITE;
        w_wr_addr     = r_col;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accum_nxt  = i_accum;
                    w_col_nxt    = '0;
                    w_settle_nxt = '0;
                    w_state_nxt  = ST_SELECT;
                end else if (i_flush) begin
                    w_y_index_nxt = '0;
                    w_state_nxt   = ST_DRAIN;
                end
            end
            ST_SELECT: begin
                if (r_settle == SETTLE_LAST) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = ST_CONVERT;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end
            ST_CONVERT: begin
                if (i_adc_valid) begin
                    w_wr_en = 1'b1;
                    w_wr_op = r_accum_mode ? ACC_OP_ADD : ACC_OP_OVERWRITE;
                    if (r_col == COL_LAST) begin
                        w_col_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_col_nxt   = r_col + 1'b1;
                        w_state_nxt = ST_SELECT;
                    end
                end
            end
            ST_DRAIN: begin
                w_wr_addr = r_y_index;
                if (i_y_ready) begin
                    w_wr_en = 1'b1;
                    w_wr_op = ACC_OP_CLEAR;
                    if (r_y_index == COL_LAST) begin
                        w_y_index_nxt = '0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_y_index_nxt = r_y_index + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // mux_sel is loaded as a column's SELECT phase begins and holds everywhere else.
    assign w_mux_nxt = (w_state_nxt == ST_SELECT) ? w_col_nxt : r_mux_sel;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_settle     <= '0;
            r_accum_mode <= 1'b0;
            r_mux_sel    <= '0;
            r_adc_req    <= 1'b0;
            r_y_valid    <= 1'b0;
            r_y_index    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_settle     <= w_settle_nxt;
            r_accum_mode <= w_accum_nxt;
            r_mux_sel    <= w_mux_nxt;
            r_adc_req    <= (w_state_nxt == ST_CONVERT);
            r_y_valid    <= (w_state_nxt == ST_DRAIN);
            r_y_index    <= w_y_index_nxt;
            r_done       <= w_done_nxt;
        end
    end

    mcc_acc_bank #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc_bank (
        .clk       (clk),
        .rstn      (rstn),
        .i_wr_en   (w_wr_en),
        .i_wr_op   (w_wr_op),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (i_adc_data),
        .i_rd_addr (r_y_index),
        .o_rd_data (w_rd_data)
    );

    assign o_mux_sel   = r_mux_sel;
    assign o_adc_req   = r_adc_req;
    assign o_y_value   = r_y_valid ? w_rd_data : '0;
    assign o_y_index   = r_y_index;
    assign o_y_valid   = r_y_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mcc_adc_collector.sv
// Scoreboard bench for mcc_adc_collector (ACC_WIDTH=10); honours MCC_ACC_SAT_EN in its model.
module tb_mcc_adc_collector;
    import mcc_pkg::*;

    localparam int ACC_W   = 10;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
    localparam int SETTLE  = 2;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     i_start = 1'b0;
    logic                     i_accum = 1'b0;
    logic                     i_flush = 1'b0;
    logic [XBAR_SIZE_BIN-1:0] o_mux_sel;
    logic                     o_adc_req;
    logic [DATA_WIDTH-1:0]    i_adc_data = '0;
    logic                     i_adc_valid = 1'b0;
    logic [ACC_W-1:0]         o_y_value;
    logic [XBAR_SIZE_BIN-1:0] o_y_index;
    logic                     o_y_valid;
    logic                     i_y_ready = 1'b0;
    logic                     o_busy;
    logic                     o_done;
    coll_state_t              o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_bank [XBAR_SIZE];
    logic [ACC_W-1:0] exp_q [$];

    mcc_adc_collector #(
        .ACC_WIDTH     (ACC_W),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_start     (i_start),
        .i_accum     (i_accum),
        .i_flush     (i_flush),
        .o_mux_sel   (o_mux_sel),
        .o_adc_req   (o_adc_req),
        .i_adc_data  (i_adc_data),
        .i_adc_valid (i_adc_valid),
        .o_y_value   (o_y_value),
        .o_y_index   (o_y_index),
        .o_y_valid   (o_y_valid),
        .i_y_ready   (i_y_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / reset / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input int col, input bit acc, input int dat);
        int s;
        if (acc) begin
            s = exp_bank[col] + dat;
`ifdef MCC_ACC_SAT_EN
            if (s > ACC_MAX) s = ACC_MAX;
`else
            s = s & ACC_MAX;
`endif
        end else begin
            s = dat;
        end
        exp_bank[col] = s;
    endtask

    task automatic model_clear();
        for (int i = 0; i < XBAR_SIZE; i++) exp_bank[i] = 0;
    endtask

    // mode: 0 -> col+1, 1 -> 255, 2 -> random. Negative column arguments disable that feature.
    task automatic run_pass(input bit acc, input int mode, input int delay_col, input int delay_len,
                            input int abort_col, input int poke_col, input bit with_flush);
        int c0, n, hi, exp_len;
        logic [DATA_WIDTH-1:0] dat;
        i_start = 1'b1;
        i_accum = acc;
        i_flush = with_flush;
        step();
        i_start = 1'b0;
        i_flush = 1'b0;
        c0 = cyc;
        check_eq("pass_busy", o_busy, 1);
        if (with_flush) begin
            check_eq("start_wins_state", o_dbg_state, ST_SELECT);
            check_eq("start_wins_y_valid", o_y_valid, 0);
        end
        for (int col = 0; col < XBAR_SIZE; col++) begin
            if (col == poke_col) begin
                i_start = 1'b1;
                i_flush = 1'b1;
                step();
                i_start = 1'b0;
                i_flush = 1'b0;
            end
            n = 0;
            while (!o_adc_req && n < 20) begin
                step();
                n++;
            end
            if (!o_adc_req) begin
                check_eq("adc_req_timeout", o_adc_req, 1);
                return;
            end
            check_eq("mux_sel", o_mux_sel, col);
            if (col == abort_col) begin
                rstn = 1'b0;
                #1;
                check_eq("abort_busy", o_busy, 0);
                check_eq("abort_state", o_dbg_state, ST_IDLE);
                check_eq("abort_adc_req", o_adc_req, 0);
                check_eq("abort_mux_sel", o_mux_sel, 0);
                step();
                rstn = 1'b1;
                model_clear();
                return;
            end
            hi = 1;
            if (col == delay_col) begin
                for (int d = 0; d < delay_len; d++) begin
                    step();
                    if (o_adc_req && o_mux_sel == 5'(col)) hi++;
                end
                check_eq("adc_req_hold", hi, delay_len + 1);
            end
            case (mode)
                0:       dat = 8'(col + 1);
                1:       dat = 8'd255;
                default: dat = 8'($urandom_range(0, 255));
            endcase
            i_adc_valid = 1'b1;
            i_adc_data  = dat;
            model_write(col, acc, int'(dat));
            step();
            i_adc_valid = 1'b0;
            check_eq("adc_req_drop", o_adc_req, 0);
        end
        exp_len = XBAR_SIZE * (SETTLE + 1) + ((delay_col >= 0) ? delay_len : 0);
        check_eq("pass_done", o_done, 1);
        check_eq("pass_len", cyc - c0, exp_len);
        step();
        check_eq("pass_done_pulse", o_done, 0);
        check_eq("pass_idle", o_busy, 0);
    endtask

    task automatic run_flush(input int stall_idx, input int stall_len);
        int c0, idx, stalls, n;
        for (int i = 0; i < XBAR_SIZE; i++) exp_q.push_back(ACC_W'(exp_bank[i]));
        model_clear();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        c0 = cyc;
        idx = 0;
        stalls = 0;
        n = 0;
        while (idx < XBAR_SIZE && n < 200) begin
            if (!o_y_valid) begin
                check_eq("y_valid", o_y_valid, 1);
                break;
            end
            if (idx == stall_idx && stalls < stall_len) begin
                i_y_ready = 1'b0;
                check_eq("stall_y_index", o_y_index, idx);
                check_eq("stall_y_value", o_y_value, exp_q[0]);
                stalls++;
            end else begin
                i_y_ready = 1'b1;
                check_eq("y_index", o_y_index, idx);
                check_eq("y_value", o_y_value, exp_q.pop_front());
                idx++;
            end
            step();
            n++;
        end
        i_y_ready = 1'b0;
        exp_q.delete();
        check_eq("drain_len", cyc - c0, XBAR_SIZE + stall_len);
        check_eq("drain_done", o_done, 1);
        check_eq("drain_y_valid_low", o_y_valid, 0);
        check_eq("drain_y_index_0", o_y_index, 0);
        step();
        check_eq("drain_done_pulse", o_done, 0);
        check_eq("drain_idle", o_busy, 0);
    endtask

    initial begin
        model_clear();
        repeat (3) step();
        check_eq("rst_mux_sel", o_mux_sel, 0);
        check_eq("rst_adc_req", o_adc_req, 0);
        check_eq("rst_y_valid", o_y_valid, 0);
        check_eq("rst_y_value", o_y_value, 0);
        check_eq("rst_y_index", o_y_index, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        rstn = 1'b1;
        repeat (2) step();
        check_eq("idle_busy", o_busy, 0);

        // Reset mid-CONVERT at column 7, then the bank must drain as zeros.
        run_pass(1'b0, 0, -1, 0, 7, -1, 1'b0);
        repeat (2) step();
        run_flush(-1, 0);

        // Single overwrite pass with col+1.
        run_pass(1'b0, 0, -1, 0, -1, -1, 1'b0);
        run_flush(-1, 0);

        // Overwrite + accumulate (slow ADC at column 3), stalled drain, then empty drain.
        run_pass(1'b0, 0, -1, 0, -1, -1, 1'b0);
        run_pass(1'b1, 0, 3, 4, -1, -1, 1'b0);
        run_flush(5, 3);
        run_flush(-1, 0);

        // start/flush while busy ignored; start+flush together in IDLE takes the pass.
        run_pass(1'b0, 2, -1, 0, -1, 10, 1'b0);
        run_pass(1'b1, 2, -1, 0, -1, -1, 1'b1);
        run_flush(-1, 0);

        // Five accumulating passes of 255 exercise wrap or saturation at ACC_W bits.
        for (int p = 0; p < 5; p++) run_pass(1'b1, 1, -1, 0, -1, -1, 1'b0);
        i_adc_valid = 1'b1;
        i_adc_data  = 8'd77;
        repeat (3) step();
        i_adc_valid = 1'b0;
        check_eq("stray_adc_valid_idle", o_busy, 0);
`ifdef MCC_ACC_SAT_EN
        check_eq("model_sat", exp_bank[0], 1023);
`else
        check_eq("model_wrap", exp_bank[0], 251);
`endif
        run_flush(-1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
